rast_mem_arbiter: RTL and testbench

- Shares one Avalon-MM SDRAM master among NUM_REQ rasterizer-unit clients: vertex fetch, depth/colour fetch, z-test write-back.
- Round-robin grant with a per-grant burst limit.
- Tracks outstanding pipelined reads in a tag FIFO and routes each readdatavalid back to the client that issued the read.
- Sits between the pipeline stages and the SDRAM controller port.

---
 rtl/rast_mem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_rast_mem_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rast_mem_arbiter.sv
// Round-robin arbiter that shares one Avalon-MM SDRAM master among the
// rasterizer clients (vertex fetch, depth fetch, z-test write-back).
// A grant lasts until the grantee goes inactive, or until BURST_MAX commands
// have been accepted while another client is waiting. Pipelined read returns
// are routed back through a tag FIFO that records which client issued each
// read.
//
// Handshake: a command transfers on a cycle where the strobe (read or write)
// is high and waitrequest is low; while waitrequest is high the requester
// holds address, data, byteenable and strobe stable. readdatavalid is a
// single-cycle strobe with no back-pressure.
module rast_mem_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 26,
    parameter int MAX_PENDING = 8,
    parameter int BURST_MAX   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*32-1:0]       req_writedata,
    input  logic [NUM_REQ*4-1:0]        req_byteenable,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [31:0]                 req_readdata,
    output logic [NUM_REQ-1:0]          req_readdatavalid,
    output logic [ADDR_W-1:0]           master_address,
    output logic                        master_read,
    output logic                        master_write,
    output logic [3:0]                  master_byteenable,
    output logic [31:0]                 master_writedata,
    input  logic                        master_waitrequest,
    input  logic [31:0]                 master_readdata,
    input  logic                        master_readdatavalid,
    output logic                        idle,
    output logic                        err_orphan
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;
    localparam int BC_W  = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    localparam logic [ID_W-1:0]  LAST_RST   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_PENDING);
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(BURST_MAX - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   grant_id, grant_id_nxt;
    logic [ID_W-1:0]   last_id, last_id_nxt;
    logic [BC_W-1:0]   burst_cnt, burst_cnt_nxt;

    logic [ID_W-1:0]   tag_mem [MAX_PENDING];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [NUM_REQ-1:0] active;
    logic               any_active;
    logic [ID_W-1:0]    rr_pick;
    logic               rr_found;

    logic [ADDR_W-1:0]  g_addr;
    logic [31:0]        g_wdata;
    logic [3:0]         g_be;
    logic               g_read, g_write, g_active, other_active;
    logic               g_rd_only;

    logic grant_valid, fifo_full, accept, push, pop;

    assign active      = req_read | req_write;
    assign any_active  = |active;
    assign grant_valid = (state == S_GRANT);
    assign fifo_full   = (count == FIFO_DEPTH);

    // Next grantee: first active requester after last_id, wrapping modulo NUM_REQ.
    always_comb begin
        rr_pick  = last_id;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rr_found && active[i] && ((int'(last_id) + k) % NUM_REQ == i)) begin
                    rr_found = 1'b1;
                    rr_pick  = ID_W'(i);
                end
            end
        end
    end

    // Select the grantee's command fields and note whether anyone else is waiting.
    always_comb begin
        g_addr       = '0;
        g_wdata      = '0;
        g_be         = '0;
        g_read       = 1'b0;
        g_write      = 1'b0;
        g_active     = 1'b0;
        other_active = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                g_addr   = req_address[i*ADDR_W +: ADDR_W];
                g_wdata  = req_writedata[i*32 +: 32];
                g_be     = req_byteenable[i*4 +: 4];
                g_read   = req_read[i];
                g_write  = req_write[i];
                g_active = active[i];
            end else if (active[i]) begin
                other_active = 1'b1;
            end
        end
    end

    // A simultaneous read+write is treated as a write; only pure reads need a tag slot.
    assign g_rd_only = g_read & ~g_write;

    assign master_address    = g_addr;
    assign master_writedata  = g_wdata;
    assign master_byteenable = g_be;
    assign master_write      = grant_valid & g_write;
    assign master_read       = grant_valid & g_rd_only & ~fifo_full;

    assign accept = (master_read | master_write) & ~master_waitrequest;
    assign push   = master_read & ~master_waitrequest;
    assign pop    = master_readdatavalid & (count != '0);

    // Stall every requester except the grantee; the grantee sees the slave stall
    // plus a stall when its read has no free tag slot.
    always_comb begin
        req_waitrequest = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_id == ID_W'(i))) begin
                req_waitrequest[i] = master_waitrequest | (g_rd_only & fifo_full);
            end
        end
    end

    // Route a read return to the client recorded at the head of the tag FIFO.
    always_comb begin
        req_readdatavalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pop && (tag_mem[rd_ptr] == ID_W'(i))) begin
                req_readdatavalid[i] = 1'b1;
            end
        end
    end

    assign req_readdata = master_readdata;
    assign idle         = (state == S_IDLE) & (count == '0);

    // Grant FSM next state: pick in IDLE, release on inactivity or exhausted burst.
    always_comb begin
        state_nxt     = state;
        grant_id_nxt  = grant_id;
        last_id_nxt   = last_id;
        burst_cnt_nxt = burst_cnt;
        case (state)
            S_IDLE: begin
                if (any_active) begin
                    state_nxt     = S_GRANT;
                    grant_id_nxt  = rr_pick;
                    burst_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                // Counter saturates so a late-arriving waiter ends the burst on the next accept.
                if (accept && (burst_cnt != BURST_LAST)) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
                if (!g_active || (accept && (burst_cnt == BURST_LAST) && other_active)) begin
                    state_nxt   = S_IDLE;
                    last_id_nxt = grant_id;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            grant_id  <= '0;
            last_id   <= LAST_RST;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_id_nxt;
            last_id   <= last_id_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Tag FIFO pointers, occupancy and the sticky orphan-return flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (master_readdatavalid && (count == '0)) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage: remember which client issued each accepted read.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant_id;
        end
    end

endmodule

// File: tb/tb_rast_mem_arbiter.sv
// Bench for rast_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_rast_mem_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int ADDR_W      = 26;
    localparam int MAX_PENDING = 8;
    localparam int BURST_MAX   = 4;
    localparam int ID_W        = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NUM_REQ*ADDR_W-1:0] req_address    = '0;
    logic [NUM_REQ-1:0]        req_read       = '0;
    logic [NUM_REQ-1:0]        req_write      = '0;
    logic [NUM_REQ*32-1:0]     req_writedata  = '0;
    logic [NUM_REQ*4-1:0]      req_byteenable = '0;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [31:0]               req_readdata;
    logic [NUM_REQ-1:0]        req_readdatavalid;
    logic [ADDR_W-1:0]         master_address;
    logic                      master_read;
    logic                      master_write;
    logic [3:0]                master_byteenable;
    logic [31:0]               master_writedata;
    logic                      master_waitrequest   = 1'b0;
    logic [31:0]               master_readdata      = '0;
    logic                      master_readdatavalid = 1'b0;
    logic                      idle;
    logic                      err_orphan;

    rast_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_PENDING(MAX_PENDING), .BURST_MAX(BURST_MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_address(req_address),
        .req_read(req_read),
        .req_write(req_write),
        .req_writedata(req_writedata),
        .req_byteenable(req_byteenable),
        .req_waitrequest(req_waitrequest),
        .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .master_address(master_address),
        .master_read(master_read),
        .master_write(master_write),
        .master_byteenable(master_byteenable),
        .master_writedata(master_writedata),
        .master_waitrequest(master_waitrequest),
        .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .idle(idle),
        .err_orphan(err_orphan)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset                = 1'b1;
        req_read             = '0;
        req_write            = '0;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [ADDR_W-1:0] a);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        req_address[i*ADDR_W +: ADDR_W] = a;
        req_read[i] = 1'b1;
        while (!done && n < 50) begin
            @(negedge clock);
            if (!req_waitrequest[i]) done = 1'b1;
            cyc();
            n++;
        end
        req_read[i] = 1'b0;
        chk("read_accept_in_time", done, 1'b1);
    endtask

    // ---------------- scoreboard / behavioural model ----------------
    // Grant owner as an int (-1 = none), accepts in the current grant, and the
    // expected queue of client ids for reads still awaiting their data.
    int                m_gnt    = -1;
    int                m_last   = NUM_REQ - 1;
    int                m_acc    = 0;
    bit                m_orphan = 1'b0;
    logic [ID_W-1:0]   exp_q[$];

    always @(negedge clock) begin : model_cmp
        int                 g, c;
        bit                 full, acc, w, r, oth;
        logic               exp_mr, exp_mw;
        logic [NUM_REQ-1:0] exp_wait, exp_rdv, act;

        act      = req_read | req_write;
        full     = (exp_q.size() == MAX_PENDING);
        exp_mr   = 1'b0;
        exp_mw   = 1'b0;
        exp_wait = '1;
        exp_rdv  = '0;
        w        = 1'b0;
        r        = 1'b0;
        g        = m_gnt;
        if (g >= 0) begin
            w           = req_write[g];
            r           = req_read[g] && !w;
            exp_mw      = w;
            exp_mr      = r && !full;
            exp_wait[g] = master_waitrequest || (r && full);
        end
        if (master_readdatavalid && exp_q.size() > 0) exp_rdv[exp_q[0]] = 1'b1;

        chk("cmp_master_read", master_read, exp_mr);
        chk("cmp_master_write", master_write, exp_mw);
        chk("cmp_req_waitrequest", req_waitrequest, exp_wait);
        chk("cmp_req_readdatavalid", req_readdatavalid, exp_rdv);
        chk("cmp_req_readdata", req_readdata, master_readdata);
        chk("cmp_idle", idle, (m_gnt < 0) && (exp_q.size() == 0));
        chk("cmp_err_orphan", err_orphan, m_orphan);
        if (g >= 0 && (w || r)) begin
            chk("cmp_address", master_address, req_address[g*ADDR_W +: ADDR_W]);
            chk("cmp_byteenable", master_byteenable, req_byteenable[g*4 +: 4]);
            if (w) chk("cmp_writedata", master_writedata, req_writedata[g*32 +: 32]);
        end

        if (reset) begin
            m_gnt    = -1;
            m_last   = NUM_REQ - 1;
            m_acc    = 0;
            m_orphan = 1'b0;
            exp_q.delete();
        end else begin
            acc = (exp_mr || exp_mw) && !master_waitrequest;
            if (master_readdatavalid) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                else m_orphan = 1'b1;
            end
            if (exp_mr && !master_waitrequest) exp_q.push_back(ID_W'(g));
            if (g < 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_last + k) % NUM_REQ;
                    if (m_gnt < 0 && act[c]) begin
                        m_gnt = c;
                        m_acc = 0;
                    end
                end
            end else begin
                oth = 1'b0;
                for (int j = 0; j < NUM_REQ; j++) if (j != g && act[j]) oth = 1'b1;
                if (!act[g] || (acc && m_acc >= BURST_MAX - 1 && oth)) begin
                    m_last = g;
                    m_gnt  = -1;
                end
                if (acc) m_acc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    int rr_exp[17] = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 2, 2, 2, 2, -1, 0};
    logic [31:0] il_data[3] = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3};
    logic [2:0]  il_rdv[3]  = '{3'b001, 3'b010, 3'b001};
    bit          held[NUM_REQ];
    int          spend;
    int          rdv_pct;
    int          owner;
    int          n;

    initial begin
        // Reset state
        cyc();
        cyc();
        @(negedge clock);
        chk("rst_idle", idle, 1'b1);
        chk("rst_waitrequest", req_waitrequest, 3'b111);
        chk("rst_master_strobes", {master_read, master_write}, 2'b00);
        chk("rst_readdatavalid", req_readdatavalid, 3'b000);
        chk("rst_err_orphan", err_orphan, 1'b0);
        cyc();
        reset = 1'b0;

        // Single read from requester 1
        req_address[1*ADDR_W +: ADDR_W] = 26'h0000100;
        req_read[1] = 1'b1;
        @(negedge clock);
        chk("sr_t0_no_read", master_read, 1'b0);
        cyc();
        @(negedge clock);
        chk("sr_t1_read", master_read, 1'b1);
        chk("sr_t1_addr", master_address, 26'h0000100);
        cyc();
        req_read[1] = 1'b0;
        cyc();
        cyc();
        master_readdatavalid = 1'b1;
        master_readdata      = 32'hDEADBEEF;
        @(negedge clock);
        chk("sr_t4_rdv", req_readdatavalid, 3'b010);
        chk("sr_t4_rdata", req_readdata, 32'hDEADBEEF);
        cyc();
        master_readdatavalid = 1'b0;
        @(negedge clock);
        chk("sr_t5_idle", idle, 1'b1);
        cyc();

        // Round robin with all three holding writes
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) req_writedata[i*32 +: 32] = 32'hA000_0000 | i;
        req_write = 3'b111;
        for (int t = 0; t < 17; t++) begin
            @(negedge clock);
            owner = -1;
            if (master_write) begin
                for (int i = 0; i < NUM_REQ; i++) if (!req_waitrequest[i]) owner = i;
            end
            chk("rr_owner", owner, rr_exp[t]);
            if (rr_exp[t] >= 0) chk("rr_wdata", master_writedata, 32'hA000_0000 | rr_exp[t]);
            cyc();
        end
        req_write = '0;
        cyc();
        cyc();

        // Stall stability on requester 2 while requester 0 waits
        do_reset();
        req_address[2*ADDR_W +: ADDR_W] = 26'h0002AA0;
        req_writedata[2*32 +: 32]       = 32'h5555AAAA;
        req_write[2] = 1'b1;
        cyc();
        master_waitrequest = 1'b1;
        req_write[0]       = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            chk("st_write_held", master_write, 1'b1);
            chk("st_addr_held", master_address, 26'h0002AA0);
            chk("st_data_held", master_writedata, 32'h5555AAAA);
            chk("st_all_wait", req_waitrequest, 3'b111);
            cyc();
        end
        master_waitrequest = 1'b0;
        @(negedge clock);
        chk("st_accept_wait", req_waitrequest, 3'b011);
        cyc();
        req_write[2] = 1'b0;
        cyc();
        @(negedge clock);
        chk("st_gap_no_write", master_write, 1'b0);
        cyc();
        @(negedge clock);
        chk("st_req0_granted", req_waitrequest, 3'b110);
        cyc();
        req_write[0] = 1'b0;
        cyc();
        cyc();

        // FIFO full
        do_reset();
        req_address[1*ADDR_W +: ADDR_W] = 26'h0000040;
        req_read[1] = 1'b1;
        repeat (8) cyc();
        req_write[0] = 1'b1;
        cyc();
        cyc();
        @(negedge clock);
        chk("ff_write_passes", master_write, 1'b1);
        chk("ff_write_wait", req_waitrequest, 3'b110);
        repeat (4) cyc();
        req_write[0] = 1'b0;
        cyc();
        @(negedge clock);
        chk("ff_read_blocked", master_read, 1'b0);
        chk("ff_read_wait", req_waitrequest, 3'b111);
        cyc();
        master_readdatavalid = 1'b1;
        master_readdata      = 32'h1111_1111;
        @(negedge clock);
        chk("ff_pop_cycle_blocked", master_read, 1'b0);
        chk("ff_pop_rdv", req_readdatavalid, 3'b010);
        cyc();
        master_readdatavalid = 1'b0;
        @(negedge clock);
        chk("ff_read_issues", master_read, 1'b1);
        chk("ff_read_issue_wait", req_waitrequest, 3'b101);
        cyc();
        req_read[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            master_readdatavalid = 1'b1;
            master_readdata      = 32'h2000_0000 + k;
            @(negedge clock);
            chk("ff_drain_rdv", req_readdatavalid, 3'b010);
            cyc();
        end
        master_readdatavalid = 1'b0;
        cyc();
        @(negedge clock);
        chk("ff_drained_idle", idle, 1'b1);
        cyc();

        // Interleaved returns follow issue order
        do_reset();
        do_read(0, 26'h0000A00);
        do_read(1, 26'h0000B00);
        do_read(0, 26'h0000C00);
        cyc();
        for (int k = 0; k < 3; k++) begin
            master_readdatavalid = 1'b1;
            master_readdata      = il_data[k];
            @(negedge clock);
            chk("il_rdv", req_readdatavalid, il_rdv[k]);
            chk("il_rdata", req_readdata, il_data[k]);
            cyc();
        end
        master_readdatavalid = 1'b0;
        cyc();

        // Reset abandons pending reads; late returns are orphans
        do_reset();
        do_read(2, 26'h0000D00);
        do_read(2, 26'h0000D01);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            master_readdatavalid = 1'b1;
            @(negedge clock);
            chk("rm_no_strobe", req_readdatavalid, 3'b000);
            cyc();
        end
        master_readdatavalid = 1'b0;
        @(negedge clock);
        chk("rm_err_orphan", err_orphan, 1'b1);
        chk("rm_idle", idle, 1'b1);
        cyc();

        // Randomized traffic
        do_reset();
        spend = 0;
        for (int i = 0; i < NUM_REQ; i++) held[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rdv_pct = (c / 500) % 3 == 0 ? 15 : ((c / 500) % 3 == 1 ? 50 : 90);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!held[i]) begin
                    req_read[i]  = 1'b0;
                    req_write[i] = 1'b0;
                    if ($urandom_range(0, 99) < 60) begin
                        held[i] = 1'b1;
                        if ($urandom_range(0, 1) == 1) req_read[i] = 1'b1;
                        else req_write[i] = 1'b1;
                        req_address[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
                        req_writedata[i*32 +: 32]       = $urandom();
                        req_byteenable[i*4 +: 4]        = 4'($urandom_range(0, 15));
                    end
                end
            end
            master_waitrequest   = ($urandom_range(0, 3) == 0);
            master_readdatavalid = (spend > 0) && ($urandom_range(0, 99) < rdv_pct);
            master_readdata      = $urandom();
            @(negedge clock);
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((req_read[i] || req_write[i]) && !req_waitrequest[i]) held[i] = 1'b0;
            end
            if (master_read && !master_waitrequest) spend++;
            if (master_readdatavalid) spend--;
            cyc();
        end

        // Drain outstanding reads
        req_read           = '0;
        req_write          = '0;
        master_waitrequest = 1'b0;
        n = 0;
        while (spend > 0 && n < 200) begin
            master_readdatavalid = 1'b1;
            master_readdata      = $urandom();
            @(negedge clock);
            spend--;
            cyc();
            n++;
        end
        master_readdatavalid = 1'b0;
        chk("drain_in_time", spend, 0);
        cyc();
        @(negedge clock);
        chk("final_idle", idle, 1'b1);
        chk("final_no_orphan", err_orphan, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
